// File: rtl/mul_arb_pkg.sv
// Shared types for mul_share_arbiter: control FSM states, the per-stage
// ownership tag, and the wrap-around index helper used for round-robin.
package mul_arb_pkg;

    // Widest requester tag (NUM_REQ up to 16).
    localparam int MAX_ID_W = 4;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        DRAINING     = 2'd1,
        IDLE_DRAINED = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    // (base + off) mod n, for base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request arbiter: one-hot grant plus encoded index. With MUL_ARB_RR_EN
// defined it searches from ptr with wrap-around; otherwise lowest index wins.
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
`ifdef MUL_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

`ifdef MUL_ARB_RR_EN
    logic [IDX_W-1:0] cand;
`endif
    logic found;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop
        // leaves it unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        found = 1'b0;
`ifdef MUL_ARB_RR_EN
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'(wrap_add(int'(ptr), off, N));
            if (!found && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
                found       = 1'b1;
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                found    = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters and tags each
// product with its owner. Arbitration mode selected by MUL_ARB_RR_EN.
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MUL = WIDTH_A + WIDTH_B,
    parameter int STAGE     = 2,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    input  logic                         drain,
    output logic                         idle,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WIDTH_MUL-1:0]         rsp_data,
    output logic                         mul_pip_en,
    output logic [WIDTH_A-1:0]           mul_a,
    output logic [WIDTH_B-1:0]           mul_b,
    input  logic [WIDTH_MUL-1:0]         mul_out
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               stall;
    logic               accept;
    logic               any_tag_valid;
    state_t             state_q, state_d;

`ifdef MUL_ARB_RR_EN
    logic [ID_W-1:0] ptr_q;

    // NOTE: clocked state uses <= so every flop samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= ID_W'(wrap_add(int'(grant_idx), 1, NUM_REQ));
        end
    end
`endif

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (req_valid),
`ifdef MUL_ARB_RR_EN
        .ptr   (ptr_q),
`endif
        .grant (grant),
        .idx   (grant_idx)
    );

    // Ready is gated by reset so requesters see 0 while rst_n is low.
    assign req_ready  = (rst_n && !stall && !drain) ? grant : '0;
    assign accept     = |(req_valid & req_ready);
    assign mul_pip_en = ~stall;
    assign rsp_data   = mul_out;
    assign idle       = ~any_tag_valid & ~accept;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && grant[i]) begin
                mul_a = req_a[i*WIDTH_A +: WIDTH_A];
                mul_b = req_b[i*WIDTH_B +: WIDTH_B];
            end
        end
    end

    generate
        if (STAGE == 0) begin : g_comb
            // Combinational multiplier: response leaves with the accept, and
            // rsp_ready is required to be tied high in this configuration.
            assign stall         = 1'b0;
            assign any_tag_valid = 1'b0;
            assign rsp_valid     = accept;
            assign rsp_id        = accept ? grant_idx : '0;
        end else begin : g_pipe
            tag_t tags [STAGE];

            // NOTE: the tag line is a few flops rather than a RAM, so it is
            // reset in full; that drops in-flight work and zeroes rsp_id.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGE; i++) begin
                        tags[i] <= '0;
                    end
                end else if (mul_pip_en) begin
                    tags[0] <= '{valid: accept, id: MAX_ID_W'(grant_idx)};
                    for (int i = 1; i < STAGE; i++) begin
                        tags[i] <= tags[i-1];
                    end
                end
            end

            always_comb begin
                any_tag_valid = 1'b0;
                for (int i = 0; i < STAGE; i++) begin
                    any_tag_valid = any_tag_valid | tags[i].valid;
                end
            end

            assign rsp_valid = tags[STAGE-1].valid;
            assign rsp_id    = ID_W'(tags[STAGE-1].id);
            assign stall     = rsp_valid & ~rsp_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain control: leaving DRAINING early is legal; in-flight work completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (drain) begin
                    state_d = any_tag_valid ? DRAINING : IDLE_DRAINED;
                end
            end
            DRAINING: begin
                if (!drain) begin
                    state_d = RUN;
                end else if (!any_tag_valid) begin
                    state_d = IDLE_DRAINED;
                end
            end
            IDLE_DRAINED: begin
                if (!drain) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter (NUM_REQ=4, 16x16, STAGE=2) with a
// behavioural two-stage multiplier; expectations follow MUL_ARB_RR_EN.
module tb_mul_share_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WA      = 16;
    localparam int WB      = 16;
    localparam int WM      = 32;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*WA-1:0] req_a;
    logic [NUM_REQ*WB-1:0] req_b;
    logic                  drain;
    logic                  idle;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WM-1:0]         rsp_data;
    logic                  mul_pip_en;
    logic [WA-1:0]         mul_a;
    logic [WB-1:0]         mul_b;
    logic [WM-1:0]         mul_out;
    logic [WM-1:0]         p1, p2;

    int n_tests = 0;
    int n_fail  = 0;
    int g;

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH_A(WA), .WIDTH_B(WB),
        .WIDTH_MUL(WM), .STAGE(2), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .drain(drain), .idle(idle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mul_pip_en(mul_pip_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out)
    );

    // Stand-in for Multiplier_generic with STAGE=2 and pipeline_en.
    always @(posedge clk) begin
        if (mul_pip_en) begin
            p1 <= WM'(mul_a) * WM'(mul_b);
            p2 <= p1;
        end
    end
    assign mul_out = p2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        req_a[i*WA +: WA] = a;
        req_b[i*WB +: WB] = b;
    endtask

    function automatic int exp_grant(input int k);
`ifdef MUL_ARB_RR_EN
        return k % NUM_REQ;
`else
        return 0;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        drain     = 1'b0;
        rsp_ready = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_idle", idle, 1);
        check("rst_pip_en", mul_pip_en, 1);
        req_valid = '0;
        #20;
        rst_n = 1'b1;

        // All four requesters streaming.
        for (int i = 0; i < NUM_REQ; i++) set_op(i, WA'(10 + i), WB'(2 + i));
        for (int k = 0; k < 7; k++) begin
            tick();
            req_valid = (k < 5) ? 4'hF : 4'h0;
            #1;
            if (k < 5) begin
                g = exp_grant(k);
                check("stream_ready", req_ready, 64'(1) << g);
                check("stream_mul_a", mul_a, 10 + g);
            end
            if (k >= 2) begin
                g = exp_grant(k - 2);
                check("stream_rsp_valid", rsp_valid, 1);
                check("stream_rsp_id", rsp_id, g);
                check("stream_rsp_data", rsp_data, (10 + g) * (2 + g));
            end
        end
        tick();
        check("stream_end_valid", rsp_valid, 0);

        // Single requester 2: 3*5.
        tick();
        req_valid = 4'b0100;
        set_op(2, 16'd3, 16'd5);
        #1;
        check("single_ready", req_ready, 4'b0100);
        check("single_mul_a", mul_a, 3);
        check("single_mul_b", mul_b, 5);
        check("single_idle_busy", idle, 0);
        tick();
        req_valid = '0;
        #1;
        check("single_lat1_valid", rsp_valid, 0);
        check("single_lat1_idle", idle, 0);
        check("single_mul_a_zero", mul_a, 0);
        tick();
        check("single_rsp_valid", rsp_valid, 1);
        check("single_rsp_id", rsp_id, 2);
        check("single_rsp_data", rsp_data, 15);
        tick();
        check("single_done_valid", rsp_valid, 0);
        check("single_done_idle", idle, 1);

        // Back-pressure: rsp_ready low for three cycles.
        tick();
        req_valid = 4'b0010;
        set_op(1, 16'd20, 16'd3);
        #1;
        check("bp_ready0", req_ready, 4'b0010);
        tick();
        set_op(1, 16'd21, 16'd3);
        #1;
        check("bp_ready1", req_ready, 4'b0010);
        tick();
        set_op(1, 16'd22, 16'd3);
        #1;
        check("bp_rsp60_valid", rsp_valid, 1);
        check("bp_rsp60_data", rsp_data, 60);
        for (int s = 0; s < 3; s++) begin
            tick();
            set_op(1, 16'd23, 16'd3);
            rsp_ready = 1'b0;
            #1;
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_data", rsp_data, 63);
            check("bp_hold_id", rsp_id, 1);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_pip_en", mul_pip_en, 0);
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        check("bp_release_data", rsp_data, 63);
        check("bp_release_ready", req_ready, 4'b0010);
        check("bp_release_pip_en", mul_pip_en, 1);
        tick();
        req_valid = '0;
        #1;
        check("bp_rsp66", rsp_data, 66);
        tick();
        check("bp_rsp69", rsp_data, 69);
        check("bp_rsp69_valid", rsp_valid, 1);
        tick();
        check("bp_done_valid", rsp_valid, 0);
        check("bp_done_idle", idle, 1);

        // Drain with two products in flight.
        tick();
        req_valid = 4'b0001;
        set_op(0, 16'd7, 16'd6);
        #1;
        check("drain_acc0", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1000;
        set_op(3, 16'd9, 16'd9);
        #1;
        check("drain_acc1", req_ready, 4'b1000);
        tick();
        req_valid = 4'hF;
        drain = 1'b1;
        #1;
        check("drain_ready0", req_ready, 0);
        check("drain_idle0", idle, 0);
        check("drain_rsp0_id", rsp_id, 0);
        check("drain_rsp0_data", rsp_data, 42);
        tick();
        check("drain_ready1", req_ready, 0);
        check("drain_rsp1_valid", rsp_valid, 1);
        check("drain_rsp1_id", rsp_id, 3);
        check("drain_rsp1_data", rsp_data, 81);
        tick();
        check("drain_empty_valid", rsp_valid, 0);
        check("drain_empty_idle", idle, 1);
        check("drain_empty_ready", req_ready, 0);
        tick();
        check("drain_still_idle", idle, 1);
        drain = 1'b0;
        req_valid = '0;

        // Reset with two products in flight.
        tick();
        req_valid = 4'b0010;
        set_op(1, 16'd4, 16'd4);
        #1;
        check("rst_acc0", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0100;
        set_op(2, 16'd5, 16'd5);
        #1;
        check("rst_acc1", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        check("rst_pre_valid", rsp_valid, 1);
        check("rst_pre_data", rsp_data, 16);
        #1;
        rst_n = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("rst_mid_valid", rsp_valid, 0);
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_idle", idle, 1);
        check("rst_mid_id", rsp_id, 0);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_post_valid", rsp_valid, 0);
        end
        check("rst_post_idle", idle, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
